rs_alu: RTL
===========

# rs_alu

Reservation station for the integer ALU in the out-of-order RISC-V core. Buffers dispatched ALU/branch/jump micro-ops, snoops the two result broadcast buses for missing operands, and issues at most one fully ready entry per cycle to the combinational ALU stage directly downstream. The ALU's broadcast result feeds back into this block's wakeup logic.

## Interface
- RS_SIZE, 16, entry count, power of two, ≥2
- ROB_W, `RoB_addr, RoB index width
- clk_in  in  1  core clock; all state updates on rising edge
- rst_in  in  1  asynchronous, active-high reset
- rdy_in  in  1  global ready; low = freeze
- clear_in  in  1  branch-mispredict flush, synchronous
- dis_valid  in  1  dispatch request this cycle
- dis_op  in  6  ALU opcode from const.v (`Lui … `Sub; 0 illegal)
- dis_vj, dis_vk  in  32  operand values (vk = imm/pc where applicable)
- dis_qj_busy, dis_qk_busy  in  1  operand still pending
- dis_qj, dis_qk  in  ROB_W  producer RoB id when pending
- dis_robid  in  ROB_W  destination RoB id
- rs_full  out  1  no free entry
- cdb_alu_valid, cdb_alu_robid, cdb_alu_result  in  1/ROB_W/32  ALU broadcast
- cdb_lsb_valid, cdb_lsb_robid, cdb_lsb_result  in  1/ROB_W/32  load/store buffer broadcast
- alu_op  out  6  issued opcode, 0 = no issue
- alu_rs1, alu_rs2  out  32  issued operands
- alu_robid  out  ROB_W  issued destination

## Operation
- Entry fields: busy, op, vj, vk, qj_busy, qj, qk_busy, qk, robid, age (when configured).
- Allocation: lowest-index non-busy entry, taken from pre-edge busy vector; entry freed by issue in the same cycle is not reusable until next cycle.
- Dispatch-time capture: if a CDB bus is valid this cycle and its robid matches a pending dis_qj/dis_qk, entry stores the bus result with that operand ready. ALU bus wins if both match (cannot occur legally).
- Wakeup: every busy entry with pending qj/qk equal to a valid CDB robid captures result, clears pending flag at the edge.
- Ready = busy & !qj_busy & !qk_busy (pre-edge values). Select one ready entry; load alu_* registers, clear its busy.
- No ready entry: alu_op <= 0, alu_rs1/rs2/robid hold.
- rs_full = popcount(busy) == RS_SIZE, combinational from registers. dis_valid while rs_full is illegal; ignored, assertion in bench.
- clear_in (with rdy_in high): all busy <= 0, alu_op <= 0, dispatch that cycle dropped; highest priority.
- rdy_in low: no state change except alu_op <= 0 (prevents duplicate ALU broadcast).
- rst_in high: all busy 0, alu_op/alu_rs1/alu_rs2/alu_robid 0, rs_full 0; immediate, mid-operation included.

## Timing
- Dispatch with both operands ready at edge E: earliest alu_op valid after edge E+1; ALU result on CDB in the same cycle.
- Entry woken at edge E: issuable at edge E+1.
- Back-to-back dependent ops: producer issued at edge E, consumer woken at E+1, issued at E+2 (one bubble).
- Throughput: one issue per cycle.

## Configuration
- RS_OLDEST_FIRST_EN defined: each entry carries an age stamp from a wrapping dispatch counter (width log2(RS_SIZE)+1, compared modulo); select picks oldest ready.
- Undefined: select picks lowest-index ready entry; no age storage.

## Structure
- const.v: opcode defines, `RoB_addr, `RS_SIZE; no new package contents beyond RS size constant.
- Sub-module rs_select: combinational ready-vector to index picker (priority or age), outputs found flag and index.

## Test plan
- Reset mid-run with 5 busy entries -> alu_op=0, rs_full=0 immediately; next dispatch lands in entry 0.
- Dispatch `Add vj=3 vk=4 ready at edge 1 -> alu_op=`Add, rs1=3, rs2=4 after edge 2.
- Dispatch `Sub qj=5 pending; cdb_lsb robid=5 result=0x10 two cycles later -> issues with rs1=0x10 one edge after wakeup.
- Dispatch with qk=7 pending same cycle as cdb_alu robid=7 result=9 -> entry ready, issues next edge with rs2=9.
- Fill 16 entries all pending -> rs_full=1; clear_in -> all busy 0, rs_full=0, alu_op=0 next edge.
- Two ready entries, index 3 older than index 1 -> with RS_OLDEST_FIRST_EN index 3 issues first, without it index 1.

Source files
------------

// File: rtl/rs_alu_pkg.sv
// Shared constants for the ALU reservation station: entry count, RoB id width
// and the ALU opcode encoding (0 is reserved as "no operation / illegal").
// Optional feature macro: RS_OLDEST_FIRST_EN (age-ordered issue select).
package rs_alu_pkg;

    localparam int RS_SIZE_DEF = 16;
    localparam int ROB_W_DEF   = 5;
    localparam int OP_W        = 6;

    localparam logic [OP_W-1:0] OP_NONE  = 6'd0;
    localparam logic [OP_W-1:0] OP_LUI   = 6'd1;
    localparam logic [OP_W-1:0] OP_AUIPC = 6'd2;
    localparam logic [OP_W-1:0] OP_JAL   = 6'd3;
    localparam logic [OP_W-1:0] OP_JALR  = 6'd4;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'd5;
    localparam logic [OP_W-1:0] OP_BNE   = 6'd6;
    localparam logic [OP_W-1:0] OP_BLT   = 6'd7;
    localparam logic [OP_W-1:0] OP_BGE   = 6'd8;
    localparam logic [OP_W-1:0] OP_ADD   = 6'd20;
    localparam logic [OP_W-1:0] OP_SUB   = 6'd21;

endpackage

// File: rtl/rs_alu_select.sv
// Combinational issue picker: from the ready vector choose one entry.
// Default: lowest ready index. With RS_OLDEST_FIRST_EN: the ready entry with
// the oldest wrapping age stamp (ages differ by less than half the range,
// so the sign of the modular difference orders them).
module rs_select #(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N)
`ifdef RS_OLDEST_FIRST_EN
    ,
    parameter int AGE_W = IDX_W + 1
`endif
) (
    input  logic [N-1:0]            ready,
`ifdef RS_OLDEST_FIRST_EN
    input  logic [N-1:0][AGE_W-1:0] age,
`endif
    output logic                    found,
    output logic [IDX_W-1:0]        idx
);

`ifdef RS_OLDEST_FIRST_EN
    function automatic logic older(input logic [AGE_W-1:0] a, input logic [AGE_W-1:0] b);
        logic [AGE_W-1:0] d;
        d = a - b;
        return d[AGE_W-1];
    endfunction

    logic [AGE_W-1:0] best;

    // Scan all ready entries keeping the oldest one seen so far.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        best  = '0;
        for (int i = 0; i < N; i++) begin
            if (ready[i] && (!found || older(age[i], best))) begin
                found = 1'b1;
                idx   = IDX_W'(i);
                best  = age[i];
            end
        end
    end
`else
    // Fixed priority: lowest ready index wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (ready[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/rs_alu.sv
// Integer ALU reservation station. Holds dispatched ALU/branch/jump uops,
// snoops the ALU and LSB result buses for missing operands, and issues one
// fully ready entry per cycle into registered alu_* outputs.
// Optional feature macro: RS_OLDEST_FIRST_EN (oldest-ready issue instead of
// lowest-index-ready).
module rs_alu
    import rs_alu_pkg::*;
#(
    parameter int RS_SIZE = RS_SIZE_DEF,
    parameter int ROB_W   = ROB_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             clear_in,
    input  logic             dis_valid,
    input  logic [OP_W-1:0]  dis_op,
    input  logic [31:0]      dis_vj,
    input  logic [31:0]      dis_vk,
    input  logic             dis_qj_busy,
    input  logic             dis_qk_busy,
    input  logic [ROB_W-1:0] dis_qj,
    input  logic [ROB_W-1:0] dis_qk,
    input  logic [ROB_W-1:0] dis_robid,
    output logic             rs_full,
    input  logic             cdb_alu_valid,
    input  logic [ROB_W-1:0] cdb_alu_robid,
    input  logic [31:0]      cdb_alu_result,
    input  logic             cdb_lsb_valid,
    input  logic [ROB_W-1:0] cdb_lsb_robid,
    input  logic [31:0]      cdb_lsb_result,
    output logic [OP_W-1:0]  alu_op,
    output logic [31:0]      alu_rs1,
    output logic [31:0]      alu_rs2,
    output logic [ROB_W-1:0] alu_robid
);

    localparam int IDX_W = $clog2(RS_SIZE);

    typedef struct packed {
        logic             busy;
        logic [OP_W-1:0]  op;
        logic [31:0]      vj;
        logic [31:0]      vk;
        logic             qj_busy;
        logic [ROB_W-1:0] qj;
        logic             qk_busy;
        logic [ROB_W-1:0] qk;
        logic [ROB_W-1:0] robid;
    } rs_entry_t;

    rs_entry_t        ent_q [RS_SIZE];
    rs_entry_t        ent_d [RS_SIZE];
    logic [OP_W-1:0]  alu_op_q, alu_op_d;
    logic [31:0]      alu_rs1_q, alu_rs1_d;
    logic [31:0]      alu_rs2_q, alu_rs2_d;
    logic [ROB_W-1:0] alu_robid_q, alu_robid_d;

    logic [RS_SIZE-1:0] busy_vec;
    logic [RS_SIZE-1:0] ready_vec;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;

`ifdef RS_OLDEST_FIRST_EN
    localparam int AGE_W = IDX_W + 1;
    logic [RS_SIZE-1:0][AGE_W-1:0] age_q, age_d;
    logic [AGE_W-1:0]              age_cnt_q, age_cnt_d;
`endif

    // Operand snoop: returns {pending, value}; ALU bus has priority over LSB.
    function automatic logic [32:0] snoop(input logic pend, input logic [ROB_W-1:0] q,
                                          input logic [31:0] v);
        logic [32:0] r;
        r = {pend, v};
        if (pend) begin
            if (cdb_alu_valid && cdb_alu_robid == q)      r = {1'b0, cdb_alu_result};
            else if (cdb_lsb_valid && cdb_lsb_robid == q) r = {1'b0, cdb_lsb_result};
        end
        return r;
    endfunction

    // Busy / ready vectors from the registered (pre-edge) entry state.
    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            busy_vec[i]  = ent_q[i].busy;
            ready_vec[i] = ent_q[i].busy & ~ent_q[i].qj_busy & ~ent_q[i].qk_busy;
        end
    end

    // Allocation target: lowest-index free entry.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_vec[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign rs_full = &busy_vec;

    rs_select #(
        .N     (RS_SIZE),
        .IDX_W (IDX_W)
`ifdef RS_OLDEST_FIRST_EN
        ,
        .AGE_W (AGE_W)
`endif
    ) u_select (
        .ready (ready_vec),
`ifdef RS_OLDEST_FIRST_EN
        .age   (age_q),
`endif
        .found (sel_found),
        .idx   (sel_idx)
    );

    // Next state: freeze / flush / (wakeup + issue + dispatch).
    always_comb begin
        ent_d       = ent_q;
        alu_op_d    = OP_NONE;
        alu_rs1_d   = alu_rs1_q;
        alu_rs2_d   = alu_rs2_q;
        alu_robid_d = alu_robid_q;
`ifdef RS_OLDEST_FIRST_EN
        age_d       = age_q;
        age_cnt_d   = age_cnt_q;
`endif
        if (rdy_in) begin
            if (clear_in) begin
                for (int i = 0; i < RS_SIZE; i++) ent_d[i].busy = 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (ent_q[i].busy) begin
                        {ent_d[i].qj_busy, ent_d[i].vj} = snoop(ent_q[i].qj_busy, ent_q[i].qj, ent_q[i].vj);
                        {ent_d[i].qk_busy, ent_d[i].vk} = snoop(ent_q[i].qk_busy, ent_q[i].qk, ent_q[i].vk);
                    end
                end
                if (sel_found) begin
                    alu_op_d             = ent_q[sel_idx].op;
                    alu_rs1_d            = ent_q[sel_idx].vj;
                    alu_rs2_d            = ent_q[sel_idx].vk;
                    alu_robid_d          = ent_q[sel_idx].robid;
                    ent_d[sel_idx].busy  = 1'b0;
                end
                // Free slot is never the issuing one (issue needs busy=1).
                if (dis_valid && free_found) begin
                    ent_d[free_idx].busy  = 1'b1;
                    ent_d[free_idx].op    = dis_op;
                    ent_d[free_idx].qj    = dis_qj;
                    ent_d[free_idx].qk    = dis_qk;
                    ent_d[free_idx].robid = dis_robid;
                    {ent_d[free_idx].qj_busy, ent_d[free_idx].vj} = snoop(dis_qj_busy, dis_qj, dis_vj);
                    {ent_d[free_idx].qk_busy, ent_d[free_idx].vk} = snoop(dis_qk_busy, dis_qk, dis_vk);
`ifdef RS_OLDEST_FIRST_EN
                    age_d[free_idx] = age_cnt_q;
                    age_cnt_d       = age_cnt_q + AGE_W'(1);
`endif
                end
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ent_q       <= '{default: '0};
            alu_op_q    <= '0;
            alu_rs1_q   <= '0;
            alu_rs2_q   <= '0;
            alu_robid_q <= '0;
`ifdef RS_OLDEST_FIRST_EN
            age_q       <= '0;
            age_cnt_q   <= '0;
`endif
        end else begin
            ent_q       <= ent_d;
            alu_op_q    <= alu_op_d;
            alu_rs1_q   <= alu_rs1_d;
            alu_rs2_q   <= alu_rs2_d;
            alu_robid_q <= alu_robid_d;
`ifdef RS_OLDEST_FIRST_EN
            age_q       <= age_d;
            age_cnt_q   <= age_cnt_d;
`endif
        end
    end

    assign alu_op    = alu_op_q;
    assign alu_rs1   = alu_rs1_q;
    assign alu_rs2   = alu_rs2_q;
    assign alu_robid = alu_robid_q;

endmodule
